// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer
//
// Central stall/flush controller for the 5-stage pipeline. Merges the load-use
// hazard, a taken branch resolved in EX, instruction-fetch not ready and a
// multi-cycle data-memory access into one consistent set of per-stage
// write-enable and bubble controls. A multi-cycle memory access freezes the
// pipeline and is supervised by a timeout watchdog that parks the sequencer in
// a sticky ERROR state, which only rst leaves.
//
// Outputs are Mealy: a function of the current state and same-cycle inputs.
//
// Parameters:
//   MEM_TIMEOUT  consecutive stalled memory cycles before ERROR (1..65535)
//   CNT_W        width of the performance counters
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   hd_load_use        load-use hazard for the instruction in ID
//   ex_branch_taken    branch/jump in EX resolved taken
//   dmem_req/dmem_ack  MEM stage access request / completion
//   imem_ready         fetched instruction valid
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
//   ex_mem_write, mem_wb_bubble   per-stage pipeline register controls
//   mem_timeout        sticky memory-timeout error flag
//   seq_state          RUN=0, MEM_WAIT=1, ERROR=2
//   perf_stall_cycles  cycles with pc_write=0 (optional feature)
//   perf_flush_count   branch flushes (optional feature)
//
// Optional feature: define STALL_PERF_EN to build the saturating performance
// counters; otherwise both perf ports are tied to zero.

module pipeline_stall_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hd_load_use,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flush_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StError   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_inc;
    logic                memstall;

    assign memstall = dmem_req & ~dmem_ack;
    // wait_cnt_q is 0 in RUN, so the same increment yields 1 on the first
    // stalled cycle and counts stalled cycles inclusive of the current one.
    // It never exceeds TIMEOUT_VAL, so it cannot wrap.
    assign wait_cnt_inc = wait_cnt_q + 1'b1;

    always_comb begin
        // Free-running pipeline by default.
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        mem_timeout   = 1'b0;
        seq_state     = state_q;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;

        unique case (state_q)
            StRun, StMemWait: begin
                if (memstall) begin
                    // Freeze everything; MEM/WB gets a bubble so WB does not
                    // retire the stalled access twice.
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    if (wait_cnt_inc == TIMEOUT_VAL) begin
                        state_d = StError;
                    end else begin
                        state_d = StMemWait;
                    end
                    wait_cnt_d = wait_cnt_inc;
                end else begin
                    // Also covers ack and a dropped request in MEM_WAIT.
                    if (ex_branch_taken) begin
                        // ID holds a wrong-path instruction: other hazards moot.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (hd_load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (!imem_ready) begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                    end
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end
            end
            StError: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                if_id_flush   = 1'b1;
                id_ex_write   = 1'b0;
                id_ex_bubble  = 1'b1;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
                mem_timeout   = 1'b1;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase

        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
            mem_timeout   = 1'b0;
            seq_state     = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef STALL_PERF_EN
    logic             flush_event;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    assign flush_event = ((state_q == StRun) || (state_q == StMemWait)) &
                         ~memstall & ex_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_event && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_count  = flush_cnt_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed-vector bench for pipeline_stall_sequencer (MEM_TIMEOUT=4).
// Each step drives one cycle of inputs, checks the Mealy outputs mid-cycle,
// then advances one clock edge.

module tb_pipeline_stall_sequencer;

    localparam int unsigned CNT_W = 32;

    // Control vector order:
    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
    //  ex_mem_write, mem_wb_bubble, mem_timeout}
    localparam logic [7:0] C_RESET  = 8'b0010_1010;
    localparam logic [7:0] C_NORMAL = 8'b1101_0100;
    localparam logic [7:0] C_LU     = 8'b0001_1100;
    localparam logic [7:0] C_BRANCH = 8'b1111_1100;
    localparam logic [7:0] C_IMISS  = 8'b0111_0100;
    localparam logic [7:0] C_STALL  = 8'b0000_0010;
    localparam logic [7:0] C_ERROR  = 8'b0010_1011;

    logic clk = 1'b0;
    logic rst, hd_load_use, ex_branch_taken, dmem_req, dmem_ack, imem_ready;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic ex_mem_write, mem_wb_bubble, mem_timeout;
    logic [1:0] seq_state;
    logic [CNT_W-1:0] perf_stall_cycles, perf_flush_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    bit perf_valid = 1'b0;

    always #5 clk = ~clk;

    pipeline_stall_sequencer #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .hd_load_use      (hd_load_use),
        .ex_branch_taken  (ex_branch_taken),
        .dmem_req         (dmem_req),
        .dmem_ack         (dmem_ack),
        .imem_ready       (imem_ready),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_write      (id_ex_write),
        .id_ex_bubble     (id_ex_bubble),
        .ex_mem_write     (ex_mem_write),
        .mem_wb_bubble    (mem_wb_bubble),
        .mem_timeout      (mem_timeout),
        .seq_state        (seq_state),
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_count (perf_flush_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs, update counter model, clock.
    task automatic step(input string tag, input logic r, input logic lu, input logic br,
                        input logic req, input logic ack, input logic imr,
                        input logic [7:0] ctrl, input logic [1:0] st);
        logic [9:0] obs;
        rst             = r;
        hd_load_use     = lu;
        ex_branch_taken = br;
        dmem_req        = req;
        dmem_ack        = ack;
        imem_ready      = imr;
        #2;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, mem_timeout, seq_state};
        check_val({tag, " ctrl"}, 32'(obs), 32'({ctrl, st}));
        if (perf_valid) begin
`ifdef STALL_PERF_EN
            check_val({tag, " perf_stall"}, perf_stall_cycles, 32'(exp_stall));
            check_val({tag, " perf_flush"}, perf_flush_count, 32'(exp_flush));
`else
            check_val({tag, " perf_stall"}, perf_stall_cycles, 32'd0);
            check_val({tag, " perf_flush"}, perf_flush_count, 32'd0);
`endif
        end
        if (r) begin
            exp_stall  = 0;
            exp_flush  = 0;
            perf_valid = 1'b1;
        end else begin
            if (!ctrl[7]) exp_stall++;
            if (br && ctrl[7]) exp_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hd_load_use = 1'b0; ex_branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ack = 1'b0; imem_ready = 1'b1;
        #1;
        //    tag          rst lu br req ack imr  ctrl      state
        step("reset0",     1, 0, 0, 0, 0, 1, C_RESET,  2'd0);
        step("reset1",     1, 0, 0, 0, 0, 1, C_RESET,  2'd0);
        step("run",        0, 0, 0, 0, 0, 1, C_NORMAL, 2'd0);
        step("load_use",   0, 1, 0, 0, 0, 1, C_LU,     2'd0);
        step("after_lu",   0, 0, 0, 0, 0, 1, C_NORMAL, 2'd0);
        step("br_prio",    0, 1, 1, 0, 0, 0, C_BRANCH, 2'd0);
        step("imiss",      0, 0, 0, 0, 0, 0, C_IMISS,  2'd0);
        step("lu_over_im", 0, 1, 0, 0, 0, 0, C_LU,     2'd0);
        step("run2",       0, 0, 0, 0, 0, 1, C_NORMAL, 2'd0);
        // Memory stall for three cycles with a branch held, ack on the fourth.
        step("mw_enter",   0, 0, 1, 1, 0, 1, C_STALL,  2'd0);
        step("mw_hold1",   0, 0, 1, 1, 0, 1, C_STALL,  2'd1);
        step("mw_hold2",   0, 0, 1, 1, 0, 1, C_STALL,  2'd1);
        step("mw_ack_br",  0, 0, 1, 1, 1, 1, C_BRANCH, 2'd1);
        step("mw_back",    0, 0, 0, 0, 0, 1, C_NORMAL, 2'd0);
        // Zero-wait accesses never stall.
        for (int i = 0; i < 5; i++) begin
            step("zero_wait", 0, 0, 0, 1, 1, 1, C_NORMAL, 2'd0);
        end
        // Request dropped while waiting counts as completion.
        step("drop_enter", 0, 0, 0, 1, 0, 1, C_STALL,  2'd0);
        step("drop_req",   0, 0, 0, 0, 0, 1, C_NORMAL, 2'd1);
        step("drop_back",  0, 0, 0, 0, 0, 1, C_NORMAL, 2'd0);
        // Timeout after exactly 4 stalled cycles.
        step("to_c1",      0, 0, 0, 1, 0, 1, C_STALL,  2'd0);
        step("to_c2",      0, 0, 0, 1, 0, 1, C_STALL,  2'd1);
        step("to_c3",      0, 0, 0, 1, 0, 1, C_STALL,  2'd1);
        step("to_c4",      0, 0, 0, 1, 0, 1, C_STALL,  2'd1);
        step("to_err",     0, 0, 0, 1, 0, 1, C_ERROR,  2'd2);
        step("err_ack",    0, 1, 1, 1, 1, 1, C_ERROR,  2'd2);
        step("err_idle",   0, 0, 0, 0, 0, 1, C_ERROR,  2'd2);
        step("err_rst",    1, 0, 0, 0, 0, 1, C_RESET,  2'd0);
        step("post_rst",   0, 0, 0, 0, 0, 1, C_NORMAL, 2'd0);
        step("post_br",    0, 0, 1, 0, 0, 1, C_BRANCH, 2'd0);
        step("final",      0, 0, 0, 0, 0, 1, C_NORMAL, 2'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
